// File: rtl/mag_seq_pkg.sv
// Shared constants for the HMC5883L sample sequencer: state codes, packet
// field layout and the new-packet qualifier.
package mag_seq_pkg;

    // Sequencer state codes, also visible on the seq_state debug port
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HOLD_RST = 3'd1;
    localparam logic [2:0] RUN      = 3'd2;
    localparam logic [2:0] FAULT    = 3'd3;

    // Packet layout: {xyz[79:32], timestamp[31:8], marker[7:0]}
    localparam int PKT_W   = 80;
    localparam int TS_LSB  = 8;
    localparam int XYZ_LSB = 32;
    localparam int TS_MSB  = XYZ_LSB - 1;
    localparam int TS_W    = TS_MSB - TS_LSB + 1;

    localparam logic [7:0] MAG_MARKER = 8'h4D;

    // A packet is new when it carries the marker and a timestamp we have not
    // captured yet; this also rejects the all-zero bus after interface reset.
    function automatic logic is_new_pkt(input logic [TS_LSB-1:0] marker,
                                        input logic [TS_W-1:0]   ts,
                                        input logic [TS_W-1:0]   last_ts);
        return (marker == MAG_MARKER) && (ts != last_ts);
    endfunction

endpackage

// File: rtl/mag_pkt_buffer.sv
// Single-entry packet buffer between the sequencer and the memory writer.
//
// Handshake: an entry is transferred on a clk edge where valid && ready.
// valid stays high and data stays stable until that transfer, except when a
// new packet overwrites an unconsumed entry (counted in drop_count). A load
// in the same cycle as a transfer simply refills the entry: no drop.
module mag_pkt_buffer #(
    parameter int W = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic [7:0]   drop_count
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic [7:0]   drop_q, drop_d;

    // Next-entry logic: load wins, otherwise a handshake empties the entry
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            if (valid_q && !ready && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/mag_sample_sequencer.sv
// HMC5883L sample sequencer: drives the I2C interface reset, captures new
// packets into a one-entry buffer and restarts the interface when packets
// stop arriving.
// Build option: define MAG_WATCHDOG_EN to include the watchdog, retry
// counting and FAULT state; without it RUN only exits on enable=0 or rst.
module mag_sample_sequencer
    import mag_seq_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'd500000,
    parameter logic [7:0]  RST_HOLD_CYCLES = 8'd16,
    parameter logic [3:0]  MAX_RETRIES     = 4'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PKT_W-1:0] mag_data,
    output logic             mag_rst_n,
    output logic [PKT_W-1:0] pkt_data,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic [15:0]      sample_count,
    output logic [7:0]       drop_count,
    output logic [7:0]       timeout_count,
    output logic             fault,
    output logic [2:0]       seq_state
);

    logic [2:0]      state_q, state_d;
    logic [7:0]      hold_ctr_q, hold_ctr_d;
    logic [TS_W-1:0] last_ts_q, last_ts_d;
    logic [15:0]     sample_count_q, sample_count_d;

    logic new_pkt;
    logic capture;
    logic wd_fire;
    logic wd_to_fault;

    assign new_pkt = is_new_pkt(mag_data[TS_LSB-1:0], mag_data[TS_MSB:TS_LSB], last_ts_q);
    assign capture = (state_q == RUN) && new_pkt;

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_ctr_q     <= 8'd0;
            last_ts_q      <= '0;
            sample_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            hold_ctr_q     <= hold_ctr_d;
            last_ts_q      <= last_ts_d;
            sample_count_q <= sample_count_d;
        end
    end

    // Next-state logic; enable low overrides every transition
    always_comb begin
        state_d        = state_q;
        hold_ctr_d     = 8'd0;
        last_ts_d      = last_ts_q;
        sample_count_d = sample_count_q;
        if (capture) begin
            last_ts_d      = mag_data[TS_MSB:TS_LSB];
            sample_count_d = sample_count_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (enable) state_d = HOLD_RST;
            end
            HOLD_RST: begin
                if (hold_ctr_q == RST_HOLD_CYCLES - 8'd1) begin
                    state_d = RUN;
                end else begin
                    hold_ctr_d = hold_ctr_q + 8'd1;
                end
            end
            RUN: begin
                if (wd_fire) state_d = wd_to_fault ? FAULT : HOLD_RST;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!enable) begin
            state_d    = IDLE;
            hold_ctr_d = 8'd0;
        end
    end

    // Outputs: the interface only runs out of reset in RUN
    always_comb begin
        mag_rst_n = (state_q == RUN);
        seq_state = state_q;
    end

    assign sample_count = sample_count_q;

`ifdef MAG_WATCHDOG_EN
    logic [23:0] wd_ctr_q, wd_ctr_d;
    logic [3:0]  retry_ctr_q, retry_ctr_d;
    logic [7:0]  timeout_count_q, timeout_count_d;
    logic        fault_q, fault_d;

    assign wd_fire     = (state_q == RUN) && !new_pkt && (wd_ctr_q == TIMEOUT_CYCLES - 24'd1);
    assign wd_to_fault = ((retry_ctr_q + 4'd1) == MAX_RETRIES);

    // Watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_ctr_q        <= 24'd0;
            retry_ctr_q     <= 4'd0;
            timeout_count_q <= 8'd0;
            fault_q         <= 1'b0;
        end else begin
            wd_ctr_q        <= wd_ctr_d;
            retry_ctr_q     <= retry_ctr_d;
            timeout_count_q <= timeout_count_d;
            fault_q         <= fault_d;
        end
    end

    // Watchdog counts idle RUN cycles; retries restart from IDLE or a good packet
    always_comb begin
        wd_ctr_d        = 24'd0;
        retry_ctr_d     = retry_ctr_q;
        timeout_count_d = timeout_count_q;
        if (state_q == IDLE) begin
            retry_ctr_d = 4'd0;
        end else if (state_q == RUN) begin
            if (new_pkt) begin
                retry_ctr_d = 4'd0;
            end else if (wd_fire) begin
                retry_ctr_d = retry_ctr_q + 4'd1;
                if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
            end else begin
                wd_ctr_d = wd_ctr_q + 24'd1;
            end
        end
        fault_d = fault_q || (state_d == FAULT);
    end

    assign timeout_count = timeout_count_q;
    assign fault         = fault_q;
`else
    logic unused_wd_cfg;

    assign wd_fire       = 1'b0;
    assign wd_to_fault   = 1'b0;
    assign timeout_count = 8'd0;
    assign fault         = 1'b0;
    assign unused_wd_cfg = ^{TIMEOUT_CYCLES, MAX_RETRIES};
`endif

    mag_pkt_buffer #(
        .W(PKT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .load_data (mag_data),
        .ready     (pkt_ready),
        .data      (pkt_data),
        .valid     (pkt_valid),
        .drop_count(drop_count)
    );

endmodule
